vacc: RTL and testbench

- FP32 (IEEE-754 single) accumulator that sits directly downstream of the vector multiplier.
- Consumes its product stream (dout/dout_rdy) and sums LEN consecutive products into one dot-product result.
- Uses the same level-ready convention: dout_rdy is held high until the next vector's first element is taken.

---
 rtl/vacc_if.sv | 13 +
 rtl/vacc.sv | 193 +++++++++++++++++++
 tb/tb_vacc.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/vacc_if.sv
// Stream interface between the upstream multiplier and the FP32 accumulator.
interface vacc_if;
  logic [31:0] din;
  logic        din_rdy;
  logic        clr;
  logic [31:0] dout;
  logic        dout_rdy;
  logic        busy;
  logic        err;

  modport master (output din, din_rdy, clr, input dout, dout_rdy, busy, err);
  modport slave  (input din, din_rdy, clr, output dout, dout_rdy, busy, err);
endinterface

// File: rtl/vacc.sv
// FP32 dot-product accumulator: sums LEN products from a level-ready stream
// through a fixed 7-state add sequence (UNPACK..UPDATE).
// The holding register is transparent when empty and the FSM is idle, so an
// edge seen in IDLE goes straight to the adder and acc updates 7 cycles later.
module vacc #(
  parameter int LEN = 8
) (
  input  logic  clk,
  input  logic  rst,
  vacc_if.slave bus
);
  localparam int CW = $clog2(LEN + 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_UNPACK  = 3'd1;
  localparam logic [2:0] ST_SPECIAL = 3'd2;
  localparam logic [2:0] ST_ALIGN   = 3'd3;
  localparam logic [2:0] ST_ADD     = 3'd4;
  localparam logic [2:0] ST_NORM    = 3'd5;
  localparam logic [2:0] ST_ROUND   = 3'd6;
  localparam logic [2:0] ST_UPDATE  = 3'd7;

  logic [2:0]        state_q, state_d;
  logic              din_rdy_q, din_rdy_d, hold_v_q, hold_v_d;
  logic [31:0]       hold_q, hold_d, acc_q, acc_d, op_q, op_d;
  logic [31:0]       dout_q, dout_d, res_q, res_d;
  logic [CW-1:0]     count_q, count_d, cnt_inc;
  logic              dout_rdy_q, dout_rdy_d, err_q, err_d;
  logic signed [9:0] a_e_q, a_e_d, b_e_q, b_e_d, big_e_q, big_e_d;
  logic signed [9:0] diff_q, diff_d, ne_q, ne_d;
  logic [23:0]       a_m_q, a_m_d, b_m_q, b_m_d, big_m_q, big_m_d, sml_m_q, sml_m_d;
  logic              big_s_q, big_s_d, sml_s_q, sml_s_d, zero_q, zero_d;
  logic [26:0]       aln_q, aln_d, nrm_q, nrm_d;
  logic [27:0]       sum_q, sum_d;

  logic              rise, take, a_big, spec_v, up;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [31:0]       spec_res, rres;
  logic [49:0]       wide;
  logic [24:0]       rnd;
  logic [23:0]       rm;
  logic signed [9:0] re;
  logic [7:0]        eb;

  // True exponent of an FP32 field; denormals share the -126 of the smallest normal.
  function automatic logic signed [9:0] unpk_e(input logic [7:0] f);
    return (f == 8'd0) ? -10'sd126 : $signed({2'b00, f}) - 10'sd127;
  endfunction

  assign rise   = bus.din_rdy & ~din_rdy_q;
  assign take   = (state_q == ST_IDLE) & (hold_v_q | rise);
  assign a_nan  = (&acc_q[30:23]) & (|acc_q[22:0]);
  assign b_nan  = (&op_q[30:23]) & (|op_q[22:0]);
  assign a_inf  = (&acc_q[30:23]) & ~(|acc_q[22:0]);
  assign b_inf  = (&op_q[30:23]) & ~(|op_q[22:0]);
  assign a_zero = ~(|acc_q[30:0]);
  assign b_zero = ~(|op_q[30:0]);

  // Special-case result; spec_v set when the add bypasses the arithmetic stages.
  always_comb begin
    spec_v   = 1'b1;
    spec_res = '0;
    if (a_nan | b_nan | (a_inf & b_inf & (acc_q[31] ^ op_q[31]))) spec_res = 32'hFFFF_FFFF;
    else if (a_inf)           spec_res = acc_q;
    else if (b_inf)           spec_res = op_q;
    else if (a_zero & b_zero) spec_res = {acc_q[31] & op_q[31], 31'd0};
    else                      spec_v   = 1'b0;
  end

  // Arithmetic stages; acc/op are stable for the whole add, so each stage
  // register simply follows its predecessor and is valid in its own state.
  always_comb begin
    int lz, lim, sh;
    a_e_d   = unpk_e(acc_q[30:23]);
    b_e_d   = unpk_e(op_q[30:23]);
    a_m_d   = {acc_q[30:23] != 8'd0, acc_q[22:0]};
    b_m_d   = {op_q[30:23] != 8'd0, op_q[22:0]};
    // order by magnitude so the subtract never goes negative
    a_big   = (a_e_q > b_e_q) || ((a_e_q == b_e_q) && (a_m_q >= b_m_q));
    big_m_d = a_big ? a_m_q : b_m_q;
    sml_m_d = a_big ? b_m_q : a_m_q;
    big_s_d = a_big ? acc_q[31] : op_q[31];
    sml_s_d = a_big ? op_q[31] : acc_q[31];
    big_e_d = a_big ? a_e_q : b_e_q;
    diff_d  = a_big ? a_e_q - b_e_q : b_e_q - a_e_q;
    // align: mantissa + guard + round, everything below folds into sticky
    wide = '0;
    if (diff_q > 10'sd26) aln_d = {26'd0, |sml_m_q};
    else begin
      wide  = {sml_m_q, 26'd0} >> diff_q[4:0];
      aln_d = {wide[49:24], |wide[23:0]};
    end
    sum_d  = (big_s_q == sml_s_q) ? ({1'b0, big_m_q, 3'b000} + {1'b0, aln_q})
                                  : ({1'b0, big_m_q, 3'b000} - {1'b0, aln_q});
    zero_d = (sum_d == '0);
    // normalize: carry shifts right, otherwise left by lzc clamped at -126
    lz = 27;
    for (int i = 0; i < 27; i++) if (sum_q[i]) lz = 26 - i;
    lim = int'(big_e_q) + 126;
    sh  = (lz < lim) ? lz : lim;
    if (sum_q[27]) begin
      nrm_d = {sum_q[27:2], sum_q[1] | sum_q[0]};
      ne_d  = big_e_q + 10'sd1;
    end else begin
      nrm_d = sum_q[26:0] << sh;
      ne_d  = big_e_q - 10'(sh);
    end
    // round to nearest even, then pack with overflow to signed Inf
    up  = nrm_q[2] & (nrm_q[1] | nrm_q[0] | nrm_q[3]);
    rnd = {1'b0, nrm_q[26:3]} + {24'd0, up};
    if (rnd[24]) begin rm = rnd[24:1]; re = ne_q + 10'sd1; end
    else         begin rm = rnd[23:0]; re = ne_q;          end
    eb = re[7:0] + 8'd127;
    if (zero_q)              rres = 32'd0;
    else if (re > 10'sd127)  rres = {big_s_q, 8'hFF, 23'd0};
    else if (rm[23])         rres = {big_s_q, eb, rm[22:0]};
    else                     rres = {big_s_q, 8'd0, rm[22:0]};
  end

  // Capture/holding register, FSM sequencing, accumulate and result handoff.
  always_comb begin
    state_d    = state_q;
    din_rdy_d  = bus.din_rdy;
    hold_v_d   = hold_v_q;
    hold_d     = hold_q;
    acc_d      = acc_q;
    op_d       = op_q;
    count_d    = count_q;
    dout_d     = dout_q;
    dout_rdy_d = dout_rdy_q;
    err_d      = err_q;
    res_d      = res_q;
    cnt_inc    = count_q + CW'(1);
    if (take) hold_v_d = 1'b0;
    if (rise) begin
      if (hold_v_q && !take)      err_d = 1'b1;
      else if (hold_v_q || !take) begin hold_v_d = 1'b1; hold_d = bus.din; end
    end
    case (state_q)
      ST_IDLE: if (take) begin
        op_d    = hold_v_q ? hold_q : bus.din;
        state_d = ST_UNPACK;
        if (count_q == '0) dout_rdy_d = 1'b0;
      end
      ST_UNPACK:  state_d = ST_SPECIAL;
      ST_SPECIAL: begin
        if (spec_v) begin res_d = spec_res; state_d = ST_UPDATE; end
        else state_d = ST_ALIGN;
      end
      ST_ALIGN:   state_d = ST_ADD;
      ST_ADD:     state_d = ST_NORM;
      ST_NORM:    state_d = ST_ROUND;
      ST_ROUND:   begin res_d = rres; state_d = ST_UPDATE; end
      default: begin
        state_d = ST_IDLE;
        if (cnt_inc == CW'(LEN)) begin
          dout_d = res_q; dout_rdy_d = 1'b1; acc_d = '0; count_d = '0;
        end else begin
          acc_d = res_q; count_d = cnt_inc;
        end
      end
    endcase
    if (bus.clr) begin
      state_d = ST_IDLE; acc_d = '0; count_d = '0; hold_v_d = 1'b0;
      dout_rdy_d = 1'b0; dout_d = dout_q; err_d = err_q;
    end
  end

  // State registers; reset discards any in-flight operand.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE; din_rdy_q <= 1'b0; hold_v_q <= 1'b0; hold_q <= '0;
      acc_q <= '0; op_q <= '0; count_q <= '0; dout_q <= '0; dout_rdy_q <= 1'b0;
      err_q <= 1'b0; res_q <= '0; a_e_q <= '0; b_e_q <= '0; big_e_q <= '0;
      diff_q <= '0; ne_q <= '0; a_m_q <= '0; b_m_q <= '0; big_m_q <= '0;
      sml_m_q <= '0; big_s_q <= 1'b0; sml_s_q <= 1'b0; zero_q <= 1'b0;
      aln_q <= '0; nrm_q <= '0; sum_q <= '0;
    end else begin
      state_q <= state_d; din_rdy_q <= din_rdy_d; hold_v_q <= hold_v_d; hold_q <= hold_d;
      acc_q <= acc_d; op_q <= op_d; count_q <= count_d; dout_q <= dout_d;
      dout_rdy_q <= dout_rdy_d; err_q <= err_d; res_q <= res_d; a_e_q <= a_e_d;
      b_e_q <= b_e_d; big_e_q <= big_e_d; diff_q <= diff_d; ne_q <= ne_d;
      a_m_q <= a_m_d; b_m_q <= b_m_d; big_m_q <= big_m_d; sml_m_q <= sml_m_d;
      big_s_q <= big_s_d; sml_s_q <= sml_s_d; zero_q <= zero_d;
      aln_q <= aln_d; nrm_q <= nrm_d; sum_q <= sum_d;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_rdy = dout_rdy_q;
  assign bus.busy     = (state_q != ST_IDLE) | hold_v_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_vacc.sv
// Directed bench for vacc: one LEN=4 and one LEN=2 instance on a shared clock/reset.
module tb_vacc;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vacc_if b4();
  vacc_if b2();

  vacc #(.LEN(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  vacc #(.LEN(2)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  // one operand on the LEN=2 instance: single-cycle din_rdy pulse, then let the add finish
  task automatic op2(input logic [31:0] v);
    @(negedge clk); b2.din = v; b2.din_rdy = 1'b1;
    @(negedge clk); b2.din_rdy = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    b4.din = '0; b4.din_rdy = 1'b0; b4.clr = 1'b0;
    b2.din = '0; b2.din_rdy = 1'b0; b2.clr = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({b4.dout, b4.dout_rdy, b4.busy, b4.err} !== 35'd0) begin
      errors++; $display("FAIL reset_len4: outputs=%h expected 0", {b4.dout, b4.dout_rdy, b4.busy, b4.err});
    end
    checks++;
    if ({b2.dout, b2.dout_rdy, b2.busy, b2.err} !== 35'd0) begin
      errors++; $display("FAIL reset_len2: outputs=%h expected 0", {b2.dout, b2.dout_rdy, b2.busy, b2.err});
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({b2.dout_rdy, b2.busy, b2.err} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset: rdy/busy/err=%b expected 000", {b2.dout_rdy, b2.busy, b2.err});
    end
  endtask

  task automatic test_len4;
    logic [31:0] v[4];
    v = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); b4.din = v[k]; b4.din_rdy = 1'b1;
      @(negedge clk); b4.din_rdy = 1'b0;
      if (k < 3) repeat (10) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (b4.dout_rdy !== 1'b0 || b4.busy !== 1'b1) begin
      errors++; $display("FAIL len4_early: rdy=%b busy=%b expected rdy=0 busy=1", b4.dout_rdy, b4.busy);
    end
    @(negedge clk);
    checks++;
    if (b4.dout_rdy !== 1'b1 || b4.dout !== 32'h4120_0000) begin
      errors++; $display("FAIL len4_sum: rdy=%b dout=%h expected rdy=1 dout=41200000", b4.dout_rdy, b4.dout);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (b4.dout_rdy !== 1'b1) begin
      errors++; $display("FAIL len4_level: rdy=%b expected 1", b4.dout_rdy);
    end
    b4.din = 32'h3F80_0000; b4.din_rdy = 1'b1;
    @(negedge clk); b4.din_rdy = 1'b0;
    checks++;
    if (b4.dout_rdy !== 1'b0 || b4.busy !== 1'b1 || b4.dout !== 32'h4120_0000) begin
      errors++; $display("FAIL len4_drop: rdy=%b busy=%b dout=%h expected 0 1 41200000", b4.dout_rdy, b4.busy, b4.dout);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_arith;
    logic [31:0] va[7], vb[7], ve[7];
    string       nm[7];
    va = '{32'h3F80_0000, 32'h0000_0001, 32'h3F80_0000, 32'h3F80_0001, 32'h7F80_0000, 32'h7F7F_FFFF, 32'h7FC0_0000};
    vb = '{32'hBF80_0000, 32'h0000_0001, 32'h3380_0000, 32'h3380_0000, 32'hFF80_0000, 32'h7F7F_FFFF, 32'h3F80_0000};
    ve = '{32'h0000_0000, 32'h0000_0002, 32'h3F80_0000, 32'h3F80_0002, 32'hFFFF_FFFF, 32'h7F80_0000, 32'hFFFF_FFFF};
    nm = '{"cancel", "denorm", "tie_even_kept", "tie_round_up", "inf_minus_inf", "overflow", "nan"};
    for (int k = 0; k < 7; k++) begin
      op2(va[k]); op2(vb[k]);
      checks++;
      if (b2.dout !== ve[k] || b2.dout_rdy !== 1'b1) begin
        errors++; $display("FAIL %s: dout=%h rdy=%b expected %h rdy=1", nm[k], b2.dout, b2.dout_rdy, ve[k]);
      end
    end
  endtask

  task automatic test_clr;
    op2(32'h3F80_0000);
    @(negedge clk); b2.clr = 1'b1; b2.din = 32'h4100_0000; b2.din_rdy = 1'b1;
    @(negedge clk); b2.clr = 1'b0; b2.din_rdy = 1'b0;
    checks++;
    if (b2.busy !== 1'b0 || b2.err !== 1'b0 || b2.dout !== 32'hFFFF_FFFF || b2.dout_rdy !== 1'b0) begin
      errors++; $display("FAIL clr_abort: busy=%b err=%b dout=%h rdy=%b expected 0 0 ffffffff 0", b2.busy, b2.err, b2.dout, b2.dout_rdy);
    end
    repeat (2) @(negedge clk);
    op2(32'h4000_0000); op2(32'h4000_0000);
    checks++;
    if (b2.dout !== 32'h4080_0000 || b2.dout_rdy !== 1'b1) begin
      errors++; $display("FAIL clr_restart: dout=%h rdy=%b expected 40800000 rdy=1", b2.dout, b2.dout_rdy);
    end
    @(negedge clk); b2.clr = 1'b1;
    @(negedge clk); b2.clr = 1'b0;
    checks++;
    if (b2.dout_rdy !== 1'b0 || b2.dout !== 32'h4080_0000) begin
      errors++; $display("FAIL clr_keep_dout: rdy=%b dout=%h expected rdy=0 dout=40800000", b2.dout_rdy, b2.dout);
    end
  endtask

  // A (edge P0) goes straight in, B (P2) waits in the holding register,
  // C (P4) finds it full and is lost; B completes at P15.
  task automatic test_back_to_back;
    @(negedge clk); b2.din = 32'h3F80_0000; b2.din_rdy = 1'b1;
    for (int c = 0; c <= 15; c++) begin
      @(negedge clk);
      if (c <= 14) begin
        checks++;
        if (b2.busy !== 1'b1) begin
          errors++; $display("FAIL b2b_busy cycle %0d: busy=%b expected 1", c, b2.busy);
        end
      end
      if (c == 3) begin
        checks++;
        if (b2.err !== 1'b0) begin errors++; $display("FAIL b2b_err_early: err=%b expected 0", b2.err); end
      end
      if (c == 4) begin
        checks++;
        if (b2.err !== 1'b1) begin errors++; $display("FAIL b2b_err: err=%b expected 1", b2.err); end
      end
      if (c == 15) begin
        checks++;
        if (b2.dout !== 32'h4040_0000 || b2.dout_rdy !== 1'b1 || b2.busy !== 1'b0) begin
          errors++; $display("FAIL b2b_sum: dout=%h rdy=%b busy=%b expected 40400000 1 0", b2.dout, b2.dout_rdy, b2.busy);
        end
      end
      case (c)
        0: b2.din_rdy = 1'b0;
        1: begin b2.din = 32'h4000_0000; b2.din_rdy = 1'b1; end
        2: b2.din_rdy = 1'b0;
        3: begin b2.din = 32'h4080_0000; b2.din_rdy = 1'b1; end
        4: b2.din_rdy = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk); b2.din = 32'h4040_0000; b2.din_rdy = 1'b1;
    @(negedge clk); b2.din_rdy = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (b2.busy !== 1'b1 || b2.err !== 1'b1) begin
      errors++; $display("FAIL arst_pre: busy=%b err=%b expected 1 1", b2.busy, b2.err);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({b2.dout, b2.dout_rdy, b2.busy, b2.err} !== 35'd0) begin
      errors++; $display("FAIL arst_clear: outputs=%h expected 0", {b2.dout, b2.dout_rdy, b2.busy, b2.err});
    end
    @(negedge clk); rst = 1'b1;
    op2(32'h4040_0000); op2(32'h3F80_0000);
    checks++;
    if (b2.dout !== 32'h4080_0000 || b2.dout_rdy !== 1'b1 || b2.err !== 1'b0) begin
      errors++; $display("FAIL arst_after: dout=%h rdy=%b err=%b expected 40800000 1 0", b2.dout, b2.dout_rdy, b2.err);
    end
  endtask

  initial begin
    test_reset();
    test_len4();
    test_arith();
    test_clr();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
